branch_queue: RTL and testbench

BRANCH_QUEUE -- requirements
Module: branch_queue

---
 rtl/branch_queue.sv | 122 ++++++++++++
 tb/tb_branch_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/branch_queue.sv
// branch_queue: circular buffer tracking in-flight conditional branches from fetch through in-order resolve to commit.
module branch_queue #(
  parameter int DEPTH          = 4,
  parameter int PATTERN_WIDTH  = 8,
  parameter int INST_MEM_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue,
  input  logic [PATTERN_WIDTH-1:0]  issue_pattern,
  input  logic [1:0]                issue_prediction,
  input  logic [INST_MEM_WIDTH-1:0] issue_alt_addr,
  input  logic                      resolve,
  input  logic                      resolve_taken,
  input  logic                      commit,
  output logic                      full,
  output logic                      commit_ready,
  output logic                      b_commit,
  output logic [PATTERN_WIDTH-1:0]  pattern_end,
  output logic [1:0]                prediction_end,
  output logic                      failure,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure,
  output logic                      flush
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head_q, head_d, rptr_q, rptr_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic [PATTERN_WIDTH-1:0] pat_q [DEPTH];
  logic [PATTERN_WIDTH-1:0] pat_d [DEPTH];
  logic [1:0] pred_q [DEPTH];
  logic [1:0] pred_d [DEPTH];
  logic [INST_MEM_WIDTH-1:0] alt_q [DEPTH];
  logic [INST_MEM_WIDTH-1:0] alt_d [DEPTH];
  logic [DEPTH-1:0] resolved_q, resolved_d, mis_q, mis_d;
  logic b_commit_q, b_commit_d, failure_q, failure_d;
  logic [PATTERN_WIDTH-1:0] pattern_end_q, pattern_end_d;
  logic [1:0] prediction_end_q, prediction_end_d;
  logic [INST_MEM_WIDTH-1:0] addr_q, addr_d;
  logic commit_acc, mis_commit, quiet, issue_acc, resolve_acc;

  assign full            = count_q == (PW+1)'(DEPTH);
  assign commit_ready    = count_q != '0 && resolved_q[head_q];
  assign b_commit        = b_commit_q;
  assign failure         = failure_q;
  assign flush           = b_commit_q & failure_q;
  assign pattern_end     = pattern_end_q;
  assign prediction_end  = prediction_end_q;
  assign addr_on_failure = addr_q;

  always_comb begin
    commit_acc  = commit && commit_ready;
    mis_commit  = commit_acc && mis_q[head_q];
    quiet       = flush || mis_commit;
    issue_acc   = issue && !quiet && (!full || commit_acc);
    resolve_acc = resolve && !quiet && (rptr_q != tail_q || full) && !resolved_q[rptr_q];
    head_d = head_q;
    rptr_d = rptr_q;
    tail_d = tail_q;
    pat_d = pat_q;
    pred_d = pred_q;
    alt_d = alt_q;
    resolved_d = resolved_q;
    mis_d = mis_q;
    b_commit_d = commit_acc;
    failure_d = mis_commit;
    pattern_end_d = commit_acc ? pat_q[head_q] : pattern_end_q;
    prediction_end_d = commit_acc ? pred_q[head_q] : prediction_end_q;
    addr_d = commit_acc ? alt_q[head_q] : addr_q;
    count_d = count_q + (PW+1)'(issue_acc) - (PW+1)'(commit_acc);
    if (issue_acc) begin
      pat_d[tail_q] = issue_pattern;
      pred_d[tail_q] = issue_prediction;
      alt_d[tail_q] = issue_alt_addr;
      resolved_d[tail_q] = 1'b0;
      mis_d[tail_q] = 1'b0;
      tail_d = tail_q + 1'b1;
    end
    // the mispredict test uses the direction stored with the entry at issue time
    if (resolve_acc) begin
      resolved_d[rptr_q] = 1'b1;
      mis_d[rptr_q] = pred_q[rptr_q][1] ^ resolve_taken;
      rptr_d = rptr_q + 1'b1;
    end
    if (commit_acc) head_d = head_q + 1'b1;
    if (mis_commit) begin
      head_d = '0;
      rptr_d = '0;
      tail_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    pat_q <= pat_d;
    pred_q <= pred_d;
    alt_q <= alt_d;
    mis_q <= mis_d;
    if (reset) begin
      head_q <= '0;
      rptr_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      resolved_q <= '0;
      b_commit_q <= 1'b0;
      failure_q <= 1'b0;
      pattern_end_q <= '0;
      prediction_end_q <= '0;
      addr_q <= '0;
    end else begin
      head_q <= head_d;
      rptr_q <= rptr_d;
      tail_q <= tail_d;
      count_q <= count_d;
      resolved_q <= resolved_d;
      b_commit_q <= b_commit_d;
      failure_q <= failure_d;
      pattern_end_q <= pattern_end_d;
      prediction_end_q <= prediction_end_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: tb/tb_branch_queue.sv
// tb_branch_queue: directed scenarios with a retirement scoreboard checked whenever b_commit fires.
module tb_branch_queue;
  logic clk = 1'b0, reset = 1'b1;
  logic issue = 1'b0, resolve = 1'b0, resolve_taken = 1'b0, commit = 1'b0;
  logic [7:0] issue_pattern = '0;
  logic [1:0] issue_prediction = '0;
  logic [31:0] issue_alt_addr = '0;
  logic full, commit_ready, b_commit, failure, flush;
  logic [7:0] pattern_end;
  logic [1:0] prediction_end;
  logic [31:0] addr_on_failure;
  int compared = 0, mismatched = 0;
  logic mon_en = 1'b0;
  typedef struct {
    logic [7:0] pat;
    logic [1:0] pred;
    logic [31:0] alt;
    logic fail;
  } exp_t;
  exp_t sb [$];

  branch_queue #(.DEPTH(4), .PATTERN_WIDTH(8), .INST_MEM_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .issue(issue), .issue_pattern(issue_pattern),
    .issue_prediction(issue_prediction), .issue_alt_addr(issue_alt_addr),
    .resolve(resolve), .resolve_taken(resolve_taken), .commit(commit),
    .full(full), .commit_ready(commit_ready), .b_commit(b_commit),
    .pattern_end(pattern_end), .prediction_end(prediction_end), .failure(failure),
    .addr_on_failure(addr_on_failure), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (b_commit === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_b_commit", 32'(b_commit), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pattern_end", 32'(pattern_end), 32'(e.pat));
        chk("prediction_end", 32'(prediction_end), 32'(e.pred));
        chk("addr_on_failure", addr_on_failure, e.alt);
        chk("failure", 32'(failure), 32'(e.fail));
        chk("flush", 32'(flush), 32'(e.fail));
      end
    end else begin
      chk("idle_failure", 32'(failure), 32'd0);
      chk("idle_flush", 32'(flush), 32'd0);
    end
  end

  task automatic cyc(input logic iss, input logic [7:0] pat, input logic [1:0] pred,
                     input logic [31:0] alt, input logic res, input logic rt, input logic com);
    issue = iss; issue_pattern = pat; issue_prediction = pred; issue_alt_addr = alt;
    resolve = res; resolve_taken = rt; commit = com;
    @(posedge clk); #1;
    issue = 1'b0; resolve = 1'b0; commit = 1'b0;
  endtask

  task automatic iss(input logic [7:0] pat, input logic [1:0] pred, input logic [31:0] alt);
    cyc(1'b1, pat, pred, alt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic res(input logic rt);
    cyc(1'b0, 8'h0, 2'b0, 32'h0, 1'b1, rt, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h0, 2'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic com_push(input logic [7:0] pat, input logic [1:0] pred, input logic [31:0] alt,
                          input logic fl, input logic also_iss);
    exp_t e;
    e.pat = pat; e.pred = pred; e.alt = alt; e.fail = fl;
    sb.push_back(e);
    cyc(also_iss, 8'h26, 2'b11, 32'h410, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_commit_ready", 32'(commit_ready), 32'd0);
    chk("rst_b_commit", 32'(b_commit), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pattern_end", 32'(pattern_end), 32'd0);
    chk("rst_prediction_end", 32'(prediction_end), 32'd0);
    chk("rst_addr", addr_on_failure, 32'd0);
    mon_en = 1'b1;
    // correct prediction retires cleanly
    iss(8'h05, 2'b11, 32'h100);
    res(1'b1);
    chk("ready_after_resolve", 32'(commit_ready), 32'd1);
    com_push(8'h05, 2'b11, 32'h100, 1'b0, 1'b0);
    chk("b_commit_pulse", 32'(b_commit), 32'd1);
    idle();
    chk("b_commit_one_cycle", 32'(b_commit), 32'd0);
    chk("empty_not_ready", 32'(commit_ready), 32'd0);
    // mispredict flushes younger entries
    iss(8'h11, 2'b10, 32'h2A0);
    iss(8'h12, 2'b01, 32'h300);
    iss(8'h13, 2'b11, 32'h304);
    res(1'b0);
    com_push(8'h11, 2'b10, 32'h2A0, 1'b1, 1'b1);
    chk("flush_count", 32'(dut.count_q), 32'd0);
    chk("flush_ready", 32'(commit_ready), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    cyc(1'b1, 8'h77, 2'b11, 32'h999, 1'b1, 1'b1, 1'b0);
    chk("flush_cycle_count", 32'(dut.count_q), 32'd0);
    chk("flush_cycle_tail", 32'(dut.tail_q), 32'd0);
    chk("flush_cycle_rptr", 32'(dut.rptr_q), 32'd0);
    // fill, drop while full, commit+issue when full, retire across wrap
    iss(8'h21, 2'b11, 32'h400);
    iss(8'h22, 2'b00, 32'h404);
    iss(8'h23, 2'b10, 32'h408);
    iss(8'h24, 2'b01, 32'h40C);
    chk("full_at_depth", 32'(full), 32'd1);
    iss(8'h25, 2'b11, 32'h4FF);
    chk("drop_tail", 32'(dut.tail_q), 32'd0);
    chk("drop_count", 32'(dut.count_q), 32'd4);
    res(1'b1);
    com_push(8'h21, 2'b11, 32'h400, 1'b0, 1'b1);
    chk("full_after_commit_issue", 32'(full), 32'd1);
    chk("tail_wrapped", 32'(dut.tail_q), 32'd1);
    res(1'b0);
    res(1'b1);
    res(1'b0);
    res(1'b1);
    chk("rptr_wrapped", 32'(dut.rptr_q), 32'd1);
    com_push(8'h22, 2'b00, 32'h404, 1'b0, 1'b0);
    com_push(8'h23, 2'b10, 32'h408, 1'b0, 1'b0);
    com_push(8'h24, 2'b01, 32'h40C, 1'b0, 1'b0);
    com_push(8'h26, 2'b11, 32'h410, 1'b0, 1'b0);
    idle();
    chk("drained_full", 32'(full), 32'd0);
    chk("drained_count", 32'(dut.count_q), 32'd0);
    chk("head_wrapped", 32'(dut.head_q), 32'd1);
    // resolve+commit same cycle on unresolved head
    iss(8'h31, 2'b11, 32'h500);
    cyc(1'b0, 8'h0, 2'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("same_cycle_no_commit", 32'(b_commit), 32'd0);
    chk("same_cycle_ready_next", 32'(commit_ready), 32'd1);
    com_push(8'h31, 2'b11, 32'h500, 1'b0, 1'b0);
    chk("late_commit_pulse", 32'(b_commit), 32'd1);
    idle();
    // reset mid-operation
    iss(8'h51, 2'b11, 32'h700);
    iss(8'h52, 2'b11, 32'h704);
    iss(8'h53, 2'b11, 32'h708);
    res(1'b1);
    reset = 1'b1;
    cyc(1'b1, 8'h54, 2'b11, 32'h70C, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    chk("rst_mid_b_commit", 32'(b_commit), 32'd0);
    chk("rst_mid_count", 32'(dut.count_q), 32'd0);
    chk("rst_mid_ready", 32'(commit_ready), 32'd0);
    chk("rst_mid_pattern_end", 32'(pattern_end), 32'd0);
    chk("rst_mid_addr", addr_on_failure, 32'd0);
    iss(8'h41, 2'b10, 32'h600);
    chk("post_rst_tail", 32'(dut.tail_q), 32'd1);
    chk("post_rst_slot0", 32'(dut.pat_q[0]), 32'h41);
    res(1'b1);
    com_push(8'h41, 2'b10, 32'h600, 1'b0, 1'b0);
    idle();
    // resolve+commit on empty queue
    cyc(1'b0, 8'h0, 2'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("empty_b_commit", 32'(b_commit), 32'd0);
    chk("empty_pattern_hold", 32'(pattern_end), 32'h41);
    chk("empty_pred_hold", 32'(prediction_end), 32'd2);
    chk("empty_addr_hold", addr_on_failure, 32'h600);
    chk("empty_rptr", 32'(dut.rptr_q), 32'd1);
    chk("empty_count", 32'(dut.count_q), 32'd0);
    idle();
    idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
